// File: rtl/arc4_drop_core.sv
// ARC4 decryption engine with configurable key length and RC4-drop[N] keystream discard.
// Drives an external 256x8 S memory plus length-prefixed ciphertext/plaintext memories.
module arc4_drop_core #(
   parameter int KEY_BYTES = 3,
   parameter int DROP_N    = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   output logic                   rdy,
   input  logic [8*KEY_BYTES-1:0] key,
   output logic [7:0]             s_addr,
   output logic [7:0]             s_wrdata,
   output logic                   s_wren,
   input  logic [7:0]             s_rddata,
   output logic [7:0]             ct_addr,
   input  logic [7:0]             ct_rddata,
   output logic [7:0]             pt_addr,
   output logic [7:0]             pt_wrdata,
   output logic                   pt_wren
);

   typedef enum logic [4:0] {
      ST_IDLE, ST_INIT,
      ST_K1, ST_K2, ST_K3, ST_K4,
      ST_H1, ST_H2,
      ST_P1, ST_P2, ST_P3, ST_P4, ST_P5, ST_P6
   } state_t;

   localparam logic [10:0] DROP_W    = 11'(DROP_N);
   localparam logic [4:0]  KIDX_LAST = 5'(KEY_BYTES - 1);

   state_t                 r_state;
   logic [8*KEY_BYTES-1:0] r_key;
   logic [7:0]             r_i;
   logic [7:0]             r_j;
   logic [7:0]             r_si;
   logic [7:0]             r_sj;
   logic [7:0]             r_ct;
   logic [7:0]             r_k;
   logic [4:0]             r_kidx;
   logic [10:0]            r_rem;
   logic [10:0]            r_drop;

   logic [7:0]             w_key_byte [32];
   logic [7:0]             w_ksa_j;
   logic [7:0]             w_prga_j;
   logic [7:0]             w_pad_addr;
   logic [10:0]            w_total;
   logic                   w_discard;

   // Byte 0 of the key is the most significant byte of the latched vector.
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_key_byte
         if (gi < KEY_BYTES) begin : g_used
            assign w_key_byte[gi] = r_key[8*(KEY_BYTES-gi)-1 -: 8];
         end else begin : g_unused
            assign w_key_byte[gi] = 8'h00;
         end
      end
   endgenerate

   assign w_ksa_j    = r_j + s_rddata + w_key_byte[r_kidx];
   assign w_prga_j   = r_j + s_rddata;
   assign w_pad_addr = r_si + r_sj;
   assign w_total    = DROP_W + {3'b000, ct_rddata};
   assign w_discard  = (r_drop != 11'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_key   <= '0;
         r_i     <= 8'd0;
         r_j     <= 8'd0;
         r_si    <= 8'd0;
         r_sj    <= 8'd0;
         r_ct    <= 8'd0;
         r_k     <= 8'd0;
         r_kidx  <= 5'd0;
         r_rem   <= 11'd0;
         r_drop  <= 11'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (en) begin
                  r_key   <= key;
                  r_i     <= 8'd0;
                  r_state <= ST_INIT;
               end
            end
            ST_INIT: begin
               r_i <= r_i + 8'd1;
               if (r_i == 8'd255) begin
                  r_j     <= 8'd0;
                  r_kidx  <= 5'd0;
                  r_state <= ST_K1;
               end
            end
            ST_K1: r_state <= ST_K2;
            ST_K2: begin
               r_j     <= w_ksa_j;
               r_si    <= s_rddata;
               r_state <= ST_K3;
            end
            ST_K3: r_state <= ST_K4;
            ST_K4: begin
               r_i     <= r_i + 8'd1;
               r_kidx  <= (r_kidx == KIDX_LAST) ? 5'd0 : r_kidx + 5'd1;
               r_state <= (r_i == 8'd255) ? ST_H1 : ST_K1;
            end
            ST_H1: r_state <= ST_H2;
            ST_H2: begin
               r_i     <= 8'd0;
               r_j     <= 8'd0;
               r_k     <= 8'd0;
               r_rem   <= w_total;
               r_drop  <= DROP_W;
               r_state <= (w_total == 11'd0) ? ST_IDLE : ST_P1;
            end
            ST_P1: begin
               r_i     <= r_i + 8'd1;
               r_state <= ST_P2;
            end
            ST_P2: begin
               r_j     <= w_prga_j;
               r_si    <= s_rddata;
               r_state <= ST_P3;
            end
            // Ciphertext byte requested in P2 arrives now; hold it until P6.
            ST_P3: begin
               r_sj    <= s_rddata;
               r_ct    <= ct_rddata;
               r_state <= ST_P4;
            end
            ST_P4: r_state <= ST_P5;
            ST_P5: r_state <= ST_P6;
            ST_P6: begin
               if (w_discard) begin
                  r_drop <= r_drop - 11'd1;
               end else begin
                  r_k <= r_k + 8'd1;
               end
               r_rem   <= r_rem - 11'd1;
               r_state <= (r_rem == 11'd1) ? ST_IDLE : ST_P1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Memory ports are decoded from state; read data feeds addresses in the same
   // cycle so each swap step fits the one-cycle memory latency.
   always_comb begin
      rdy       = (r_state == ST_IDLE);
      s_addr    = 8'd0;
      s_wrdata  = 8'd0;
      s_wren    = 1'b0;
      ct_addr   = 8'd0;
      pt_addr   = 8'd0;
      pt_wrdata = 8'd0;
      pt_wren   = 1'b0;
      case (r_state)
         ST_INIT: begin
            s_addr   = r_i;
            s_wrdata = r_i;
            s_wren   = 1'b1;
         end
         ST_K1: s_addr = r_i;
         ST_K2: s_addr = w_ksa_j;
         ST_K3: begin
            s_addr   = r_i;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
         end
         ST_K4: begin
            s_addr   = r_j;
            s_wrdata = r_si;
            s_wren   = 1'b1;
         end
         ST_H1: ct_addr = 8'd0;
         ST_H2: begin
            pt_addr   = 8'd0;
            pt_wrdata = ct_rddata;
            pt_wren   = 1'b1;
         end
         ST_P1: s_addr = r_i + 8'd1;
         ST_P2: begin
            s_addr  = w_prga_j;
            ct_addr = r_k + 8'd1;
         end
         ST_P3: begin
            s_addr   = r_i;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
         end
         ST_P4: begin
            s_addr   = r_j;
            s_wrdata = r_si;
            s_wren   = 1'b1;
         end
         ST_P5: s_addr = w_pad_addr;
         ST_P6: begin
            if (!w_discard) begin
               pt_addr   = r_k + 8'd1;
               pt_wrdata = s_rddata ^ r_ct;
               pt_wren   = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_arc4_drop_core.sv
// Bench for arc4_drop_core: three instances (3-byte key, 4-byte key, 3-byte key with drop768)
// driven against behavioural memories and a plain RC4-drop reference model.
module tb_arc4_drop_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en        [3];
   logic        rdy       [3];
   logic [31:0] key_v     [3];
   logic [7:0]  s_addr    [3];
   logic [7:0]  s_wrdata  [3];
   logic        s_wren    [3];
   logic [7:0]  s_rddata  [3];
   logic [7:0]  ct_addr   [3];
   logic [7:0]  ct_rddata [3];
   logic [7:0]  pt_addr   [3];
   logic [7:0]  pt_wrdata [3];
   logic        pt_wren   [3];

   logic [7:0]  s_mem  [3][256];
   logic [7:0]  ct_mem [3][256];
   logic [7:0]  pt_mem [3][256];
   int          pt_cnt  [3] = '{0, 0, 0};
   int          pt1_cyc [3] = '{0, 0, 0};
   int          cyc = 0;

   int          nvec  = 0;
   int          nfail = 0;
   logic [7:0]  exp_pt [256];

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         localparam int KB = (gi == 1) ? 4 : 3;
         localparam int DN = (gi == 2) ? 768 : 0;
         arc4_drop_core #(.KEY_BYTES(KB), .DROP_N(DN)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .en        (en[gi]),
            .rdy       (rdy[gi]),
            .key       (key_v[gi][8*KB-1:0]),
            .s_addr    (s_addr[gi]),
            .s_wrdata  (s_wrdata[gi]),
            .s_wren    (s_wren[gi]),
            .s_rddata  (s_rddata[gi]),
            .ct_addr   (ct_addr[gi]),
            .ct_rddata (ct_rddata[gi]),
            .pt_addr   (pt_addr[gi]),
            .pt_wrdata (pt_wrdata[gi]),
            .pt_wren   (pt_wren[gi])
         );
      end
   endgenerate

   // Synchronous memories with one-cycle read latency, plus write bookkeeping.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int n = 0; n < 3; n++) begin
         if (s_wren[n]) s_mem[n][s_addr[n]] <= s_wrdata[n];
         s_rddata[n]  <= s_mem[n][s_addr[n]];
         ct_rddata[n] <= ct_mem[n][ct_addr[n]];
         if (pt_wren[n]) begin
            pt_mem[n][pt_addr[n]] <= pt_wrdata[n];
            pt_cnt[n] <= pt_cnt[n] + 1;
            if (pt_addr[n] == 8'd1) pt1_cyc[n] <= cyc;
         end
      end
   end

   function automatic int kb_of(input int inst);
      return (inst == 1) ? 4 : 3;
   endfunction

   function automatic int drop_of(input int inst);
      return (inst == 2) ? 768 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Plain RC4 with the first DROP_N keystream bytes thrown away.
   task automatic model(input int inst);
      int kb, dn, L, i, j, t, pad;
      int S [256];
      int kbytes [32];
      kb = kb_of(inst);
      dn = drop_of(inst);
      for (int b = 0; b < kb; b++) kbytes[b] = int'((key_v[inst] >> (8 * (kb - 1 - b))) & 32'hFF);
      for (int n = 0; n < 256; n++) S[n] = n;
      j = 0;
      for (int n = 0; n < 256; n++) begin
         j = (j + S[n] + kbytes[n % kb]) % 256;
         t = S[n]; S[n] = S[j]; S[j] = t;
      end
      L = int'(ct_mem[inst][0]);
      exp_pt[0] = 8'(L);
      i = 0;
      j = 0;
      for (int n = 0; n < dn + L; n++) begin
         i = (i + 1) % 256;
         j = (j + S[i]) % 256;
         t = S[i]; S[i] = S[j]; S[j] = t;
         pad = S[(S[i] + S[j]) % 256];
         if (n >= dn) exp_pt[n - dn + 1] = ct_mem[inst][n - dn + 1] ^ 8'(pad);
      end
   endtask

   task automatic check_pt(input int inst, input string tag);
      int L;
      L = int'(ct_mem[inst][0]);
      for (int a = 0; a <= L; a++)
         chk($sformatf("%s pt[%0d]", tag, a), 32'(pt_mem[inst][a]), 32'(exp_pt[a]));
   endtask

   task automatic wait_rdy(input int inst, input int pulse_at, output int n);
      n = 0;
      while (rdy[inst] !== 1'b1 && n < 20000) begin
         en[inst] = (n == pulse_at);
         @(negedge clk);
         n++;
      end
      en[inst] = 1'b0;
   endtask

   // One full decryption: start, check rdy drop, latency, write count and pt contents.
   task automatic run(input int inst, input string tag, input int pulse_at, output int c0);
      int n, L, cnt0;
      model(inst);
      L    = int'(ct_mem[inst][0]);
      cnt0 = pt_cnt[inst];
      en[inst] = 1'b1;
      c0 = cyc;
      @(negedge clk);
      en[inst] = 1'b0;
      chk({tag, " rdy_drop"}, 32'(rdy[inst]), 32'd0);
      wait_rdy(inst, pulse_at, n);
      chk({tag, " latency"}, 32'(cyc - c0 - 1), 32'(1282 + 6 * (drop_of(inst) + L)));
      chk({tag, " pt_writes"}, 32'(pt_cnt[inst] - cnt0), 32'(L + 1));
      check_pt(inst, tag);
   endtask

   task automatic load_random(input int inst, input int L);
      ct_mem[inst][0] = 8'(L);
      for (int a = 1; a < 256; a++) ct_mem[inst][a] = 8'($urandom);
   endtask

   initial begin
      int c0, n, cnt0, L;
      string pt_str;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         en[k]    = 1'b0;
         key_v[k] = 32'd0;
         for (int a = 0; a < 256; a++) ct_mem[k][a] = 8'h00;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset%0d rdy", k), 32'(rdy[k]), 32'd1);
         chk($sformatf("reset%0d s_wren", k), 32'(s_wren[k]), 32'd0);
         chk($sformatf("reset%0d pt_wren", k), 32'(pt_wren[k]), 32'd0);
         chk($sformatf("reset%0d addrs", k), {8'd0, s_addr[k], ct_addr[k], pt_addr[k]}, 32'd0);
         chk($sformatf("reset%0d wrdata", k), {16'd0, s_wrdata[k], pt_wrdata[k]}, 32'd0);
      end

      // Known vector: key "Key", plaintext "Plaintext".
      key_v[0] = 32'h004B6579;
      ct_mem[0][0] = 8'h09;
      ct_mem[0][1] = 8'hBB; ct_mem[0][2] = 8'hF3; ct_mem[0][3] = 8'h16;
      ct_mem[0][4] = 8'hE8; ct_mem[0][5] = 8'hD9; ct_mem[0][6] = 8'h40;
      ct_mem[0][7] = 8'hAF; ct_mem[0][8] = 8'h0A; ct_mem[0][9] = 8'hD3;
      run(0, "key3_plaintext", -1, c0);
      pt_str = "Plaintext";
      for (int a = 0; a < 9; a++)
         chk($sformatf("plaintext_char%0d", a), 32'(pt_mem[0][a+1]), 32'(pt_str[a]));

      // Known vector: key "Wiki", plaintext "pedia".
      key_v[1] = 32'h57696B69;
      ct_mem[1][0] = 8'h05;
      ct_mem[1][1] = 8'h10; ct_mem[1][2] = 8'h21; ct_mem[1][3] = 8'hBF;
      ct_mem[1][4] = 8'h04; ct_mem[1][5] = 8'h20;
      run(1, "key4_pedia", -1, c0);
      pt_str = "pedia";
      for (int a = 0; a < 5; a++)
         chk($sformatf("pedia_char%0d", a), 32'(pt_mem[1][a+1]), 32'(pt_str[a]));

      // Drop768 with a random key; first data write lands in P6 of iteration 769.
      key_v[2] = {8'd0, 24'($urandom)};
      load_random(2, 16);
      run(2, "drop768", -1, c0);
      chk("drop768 first_pt_write_cycle", 32'(pt1_cyc[2]), 32'(c0 + 1282 + 6 * 769));

      // Zero-length message.
      ct_mem[0][0] = 8'h00;
      run(0, "len0", -1, c0);

      // Random keys and lengths.
      for (int r = 0; r < 3; r++) begin
         key_v[0] = {8'd0, 24'($urandom)};
         load_random(0, int'($urandom_range(1, 40)));
         run(0, $sformatf("rand3_%0d", r), -1, c0);
      end
      key_v[1] = $urandom;
      load_random(1, int'($urandom_range(1, 255)));
      run(1, "rand4", -1, c0);

      // en pulse during KSA must be ignored.
      key_v[0] = {8'd0, 24'($urandom)};
      load_random(0, 12);
      run(0, "en_in_ksa", 500, c0);

      // Reset in the middle of PRGA, then a clean run.
      en[0] = 1'b1;
      @(negedge clk);
      en[0] = 1'b0;
      repeat (1282 + 20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst rdy", 32'(rdy[0]), 32'd1);
      chk("midrst s_wren", 32'(s_wren[0]), 32'd0);
      chk("midrst pt_wren", 32'(pt_wren[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      key_v[0] = {8'd0, 24'($urandom)};
      load_random(0, 20);
      run(0, "after_rst", -1, c0);

      // en held high: two back-to-back runs with identical results.
      key_v[0] = {8'd0, 24'($urandom)};
      load_random(0, 10);
      model(0);
      L    = 10;
      cnt0 = pt_cnt[0];
      en[0] = 1'b1;
      c0 = cyc;
      @(negedge clk);
      chk("held run1 rdy_drop", 32'(rdy[0]), 32'd0);
      n = 0;
      while (rdy[0] !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
      chk("held run1 latency", 32'(cyc - c0 - 1), 32'(1282 + 6 * L));
      check_pt(0, "held run1");
      c0 = cyc;
      @(negedge clk);
      en[0] = 1'b0;
      chk("held run2 rdy_drop", 32'(rdy[0]), 32'd0);
      wait_rdy(0, -1, n);
      chk("held run2 latency", 32'(cyc - c0 - 1), 32'(1282 + 6 * L));
      chk("held pt_writes", 32'(pt_cnt[0] - cnt0), 32'(2 * (L + 1)));
      check_pt(0, "held run2");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/arc4_drop_core.md
# arc4_drop_core

Parametrised ARC4 decryption engine, the successor to the fixed 24-bit-key decryptor. It runs S-box init, key scheduling (KSA) and keystream generation (PRGA) as one state machine, driving an external 256x8 S memory and the ciphertext/plaintext memories. It generalises the key length and adds optional RC4-drop[N] keystream discard. The core sits between the top-level control (key source or cracker) and the length-prefixed message memories.

## Interface
- KEY_BYTES, 3: key length in bytes, 1..32.
- DROP_N, 0: keystream bytes generated and discarded before decryption, 0..1024.
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  start request, accepted only when rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  in  8*KEY_BYTES  key; byte j = key[8*(KEY_BYTES-j)-1 -: 8] (byte 0 is the MSB byte). Latched on accept.
- s_addr / s_wrdata / s_wren  out  8/8/1  S memory port.
- s_rddata  in  8  S memory read data.
- ct_addr  out  8  ciphertext address.
- ct_rddata  in  8  ciphertext read data.
- pt_addr / pt_wrdata / pt_wren  out  8/8/1  plaintext write port.
- All memories have 1-cycle read latency: an address presented in cycle t returns data in cycle t+1.

## Operation
- States: IDLE, INIT, KSA (K1-K4), PRGA header (H1-H2), PRGA byte (P1-P6), then back to IDLE.
- IDLE: rdy=1 and all wren=0. When en=1, the core latches key, sets i=0, and enters INIT. rdy drops the next cycle.
- INIT: one write per cycle, S[i]=i, for i=0..255 (256 cycles).
- KSA: j starts at 0. For i=0..255:
  - K1: s_addr=i.
  - K2: j = j + S[i] + keybyte[i mod KEY_BYTES], mod 256; s_addr=j.
  - K3: write S[i]=S[j].
  - K4: write S[j]=saved S[i].
- H1: ct_addr=0. H2: latch L=ct_rddata; write pt[0]=L. Then i=0, j=0, k=0.
- PRGA iteration, repeated DROP_N+L times:
  - P1: i=i+1; s_addr=i.
  - P2: si=S[i]; j=j+si; s_addr=j; ct_addr=k+1.
  - P3: sj=S[j]; write S[i]=sj.
  - P4: write S[j]=si.
  - P5: s_addr=si+sj (mod 256).
  - P6: pad=s_rddata.
    - Discard iterations (the first DROP_N): no write.
    - Otherwise: pt_addr=k+1, pt_wrdata=pad^ct[k+1], pt_wren=1, then k=k+1.
- All index and sum arithmetic is 8-bit and wraps mod 256.
- i==j: the swap writes the same value twice, which is legal and harmless.
- L=0: only pt[0]=0 is written. Discard iterations still run.
- en while busy is ignored and not queued. en held high in IDLE starts a new run every time rdy is high.
- Only the low 8 bits of k are meaningful; L is at most 255.

## Timing
- Reset values: rdy=1; s_wren=pt_wren=0; s_addr=ct_addr=pt_addr=0; s_wrdata=pt_wrdata=0; state IDLE.
- rst in any state returns the core to IDLE on the next edge with all wren low. Partial S and pt contents are left undefined.
- A write strobe is high for exactly one cycle per write.
- Latency: en is accepted at edge e. rdy returns high at edge e + 1282 + 6*(DROP_N+L).
  - Breakdown: 256 INIT + 1024 KSA + 2 header + 6 per iteration.
- The first plaintext write occurs in the P6 of iteration DROP_N+1.

## Test plan
- KEY_BYTES=3, DROP_N=0, key=24'h4B6579, ct = {09, BB F3 16 E8 D9 40 AF 0A D3} -> pt = {09, "Plaintext"}. rdy rises 1282+54 cycles after accept.
- KEY_BYTES=4, key=32'h57696B69, ct = {05, 10 21 BF 04 20} -> pt = {05, "pedia"}. Exactly 6 pt_wren pulses.
- DROP_N=768, KEY_BYTES=3, random key, L=16 -> pt matches a software RC4-drop768 model. No pt write occurs before the 769th P6.
- L=0 with DROP_N=0 -> single write pt[0]=00. rdy returns after 1282 cycles.
- Pulse en during KSA -> ignored, output identical to a single run. Assert rst mid-PRGA -> next cycle rdy=1 and all wren=0. A fresh run after that is correct.
- en held high continuously -> back-to-back runs produce identical pt; rdy is low for exactly the computed latency each run.
